seq_multiplier16: RTL and testbench

//  Iterative radix-2 shift-add unsigned multiplier feeding the calculator

---
 rtl/seq_multiplier16_pkg.sv | 12 +
 rtl/seq_multiplier16_dp.sv | 44 ++++
 rtl/seq_multiplier16.sv | 87 ++++++++
 tb/tb_seq_multiplier16.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seq_multiplier16_pkg.sv
// Shared constants and FSM state encoding for the sequential shift-add multiplier.
package seq_multiplier16_pkg;

  localparam int unsigned MUL_WIDTH = 16;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/seq_multiplier16_dp.sv
// Shift-add datapath: holds the shifting multiplicand, multiplier and accumulator.
module mul_shift_add_dp #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     op_a_i,
  input  logic [WIDTH-1:0]     op_b_i,
  output logic [2*WIDTH-1:0]   acc_next_o
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    addend;

  // acc_next_o already includes the current partial product, so the top can
  // latch the finished product on the final step without an extra cycle.
  always_comb begin
    addend     = b_q[0] ? a_q : '0;
    acc_next_o = acc_q + addend;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (load_i) begin
      a_q   <= PW'(op_a_i);
      b_q   <= op_b_i;
      acc_q <= '0;
    end else if (step_i) begin
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      acc_q <= acc_next_o;
    end
  end

endmodule

// File: rtl/seq_multiplier16.sv
// Iterative radix-2 unsigned multiplier with start/busy/done handshake.
module seq_multiplier16
  import seq_multiplier16_pkg::*;
#(
  parameter int unsigned WIDTH    = MUL_WIDTH,
  parameter int unsigned CNT_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  mul_state_e            state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0]    product_q, product_d;
  logic [2*WIDTH-1:0]    acc_next;
  logic                  load, step;

  mul_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (load),
    .step_i     (step),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .acc_next_o (acc_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      MUL_IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = MUL_RUN;
        end
      end
      MUL_RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q + CNT_BITS'(1);
        if (cnt_q == CNT_BITS'(WIDTH - 1)) begin
          product_d = acc_next;
          state_d   = MUL_DONE;
        end
      end
      MUL_DONE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = MUL_RUN;
        end else begin
          state_d = MUL_IDLE;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= MUL_IDLE;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == MUL_RUN);
  assign done    = (state_q == MUL_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier16.sv
// Scoreboard bench for seq_multiplier16: expected products and acceptance cycles queued at start.
module tb_seq_multiplier16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] product;

  typedef struct {
    logic [31:0] prod;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_pass  = 0;

  seq_multiplier16 #(
    .WIDTH(16),
    .CNT_BITS(5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_check++;
    if (got !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("product", product, e.prod);
        check("latency", 32'(cyc - e.acc_cyc), 32'd16);
      end
    end
  end

  // Drive one start pulse at a negedge; acceptance happens at the next posedge.
  task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input bit expect_result);
    exp_t e;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    if (expect_result) begin
      e.prod    = {16'h0, a} * {16'h0, b};
      e.acc_cyc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_empty(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    reset = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;

    // 1: reset
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", product, 32'h0);

    // 2: 3*5 with busy/done profile and hold
    do_mul(16'd3, 16'd5, 1'b1);
    for (int unsigned i = 0; i < 16; i++) begin
      check($sformatf("busy_c%0d", i), 32'(busy), 32'd1);
      check($sformatf("nodone_c%0d", i), 32'(done), 32'd0);
      @(negedge clk);
    end
    check("done_pulse", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_drop", 32'(done), 32'd0);
    check("product_hold", product, 32'h0000_000F);
    wait_empty(40);

    // 3: corner operands
    do_mul(16'hFFFF, 16'hFFFF, 1'b1);
    wait_empty(40);
    check("max_product", product, 32'hFFFE_0001);
    do_mul(16'h0000, 16'h1234, 1'b1);
    wait_empty(40);
    check("zero_product", product, 32'h0);

    // 4: back-to-back with start held through the done cycle
    @(negedge clk);
    op_a  = 16'd2;
    op_b  = 16'd7;
    start = 1'b1;
    e.prod = 32'd14; e.acc_cyc = cyc + 1; sb.push_back(e);
    repeat (17) @(negedge clk);
    check("b2b_done1", 32'(done), 32'd1);
    op_a = 16'd9;
    op_b = 16'd9;
    e.prod = 32'd81; e.acc_cyc = cyc + 1; sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_gap", 32'(busy), 32'd1);
    wait_empty(40);
    check("b2b_product2", product, 32'd81);

    // 5: start during RUN is ignored
    do_mul(16'd6, 16'd7, 1'b1);
    repeat (4) @(negedge clk);
    op_a  = 16'd100;
    op_b  = 16'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_empty(40);
    repeat (20) @(negedge clk);
    check("ignore_product", product, 32'd42);
    check("ignore_idle", 32'(busy), 32'd0);

    // 6: reset mid-RUN discards the operation
    do_mul(16'h00FF, 16'h0101, 1'b0);
    repeat (7) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_product", product, 32'h0);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_still_idle", 32'(busy), 32'd0);
    do_mul(16'd4, 16'd4, 1'b1);
    wait_empty(40);
    check("after_rst_product", product, 32'd16);

    // a few random operands
    for (int unsigned i = 0; i < 4; i++) begin
      do_mul(16'($urandom), 16'($urandom), 1'b1);
      wait_empty(40);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
